// File: rtl/post_neuron_update_ctrl.sv
// Read-modify-write controller for the post-neuron state SRAM: integrate, fire, write back, clear sweep.
// Optional membrane leak is enabled with `define POST_NEURON_LEAK_EN (adds i_leak port).
module post_neuron_update_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SRAM_DEPTH   = 256,
  parameter int unsigned WEIGHT_WIDTH = 8
) (
  input  logic                    i_ck,
  input  logic                    i_rst_n,
  input  logic                    i_evt_valid,
  output logic                    o_evt_ready,
  input  logic [ADDR_WIDTH-1:0]   i_evt_addr,
  input  logic [WEIGHT_WIDTH-1:0] i_evt_weight,
  input  logic [15:0]             i_thr,
`ifdef POST_NEURON_LEAK_EN
  input  logic [7:0]              i_leak,
`endif
  input  logic                    i_clr_start,
  output logic                    o_busy,
  output logic                    o_clr_done,
  output logic                    o_spk_valid,
  output logic [ADDR_WIDTH-1:0]   o_spk_addr,
  output logic                    o_sram_cs,
  output logic                    o_sram_we,
  output logic [ADDR_WIDTH-1:0]   o_sram_a,
  output logic [DATA_WIDTH-1:0]   o_sram_d,
  input  logic [DATA_WIDTH-1:0]   i_sram_q
);

  localparam int unsigned VW   = 16;
  localparam int unsigned SW   = VW + 1;
  localparam int unsigned CW   = ADDR_WIDTH + 1;
  localparam int unsigned WEXT = SW - WEIGHT_WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_CLR} state_t;

  state_t                    r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [WEIGHT_WIDTH-1:0]   r_weight;
  logic [15:0]               r_thr;
  logic [CW-1:0]             r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                      r_rdy_arm;
  logic                      r_cs, r_we, r_spk_valid, r_clr_done, r_busy;
  logic [ADDR_WIDTH-1:0]     r_a, r_spk_addr;
  logic [DATA_WIDTH-1:0]     r_d;

  logic                      w_cs_nxt, w_we_nxt, w_spk_valid_nxt, w_clr_done_nxt, w_cap;
  logic [ADDR_WIDTH-1:0]     w_a_nxt, w_spk_addr_nxt;
  logic [DATA_WIDTH-1:0]     w_d_nxt;
  logic                      w_ready;

  logic [VW-1:0]             w_vmem, w_v1, w_s, w_vmem_new;
  logic [VW-1:0]             w_scnt, w_scnt_new;
  logic [SW-1:0]             w_sum, w_wx;
  logic                      w_fire;
  logic [DATA_WIDTH-1:0]     w_word;

  // Handshake is blocked out of reset for one cycle and whenever a clear is requested
  assign w_ready     = (r_state == S_IDLE) && r_rdy_arm && !i_clr_start;
  assign o_evt_ready = w_ready;

  assign w_vmem = i_sram_q[15:0];
  assign w_scnt = i_sram_q[31:16];

`ifdef POST_NEURON_LEAK_EN
  logic [7:0]    r_leak;
  logic [SW-1:0] w_vx, w_lx, w_dn, w_up;

  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n)   r_leak <= '0;
    else if (w_cap) r_leak <= i_leak;
  end

  assign w_vx = {w_vmem[VW-1], w_vmem};
  assign w_lx = {{(SW-8){1'b0}}, r_leak};
  assign w_dn = w_vx - w_lx;
  assign w_up = w_vx + w_lx;

  // Leak pulls the potential toward zero without crossing it
  always_comb begin
    w_v1 = w_vmem;
    if (!w_vmem[VW-1] && (w_vmem != '0)) begin
      w_v1 = w_dn[SW-1] ? '0 : w_dn[VW-1:0];
    end else if (w_vmem[VW-1]) begin
      w_v1 = (!w_up[SW-1] && (w_up != '0)) ? '0 : w_up[VW-1:0];
    end
  end
`else
  assign w_v1 = w_vmem;
`endif

  assign w_wx  = {{WEXT{r_weight[WEIGHT_WIDTH-1]}}, r_weight};
  assign w_sum = {w_v1[VW-1], w_v1} + w_wx;

  // Saturate the 17-bit sum back into the signed 16-bit range
  always_comb begin
    case ({w_sum[SW-1], w_sum[VW-1]})
      2'b01:   w_s = 16'h7FFF;
      2'b10:   w_s = 16'h8000;
      default: w_s = w_sum[VW-1:0];
    endcase
  end

  assign w_fire     = $signed(w_s) >= $signed(r_thr);
  assign w_vmem_new = w_fire ? '0 : w_s;
  assign w_scnt_new = (w_fire && (w_scnt != 16'hFFFF)) ? w_scnt + 16'd1 : w_scnt;
  assign w_word     = {w_scnt_new, w_vmem_new};
  assign w_cnt_inc  = r_cnt + CW'(1);

  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state plus next values for every registered output
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cs_nxt        = 1'b0;
    w_we_nxt        = 1'b0;
    w_a_nxt         = r_a;
    w_d_nxt         = r_d;
    w_spk_valid_nxt = 1'b0;
    w_spk_addr_nxt  = r_spk_addr;
    w_clr_done_nxt  = 1'b0;
    w_cap           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clr_start) begin
          w_state_nxt = S_CLR;
          w_cnt_nxt   = '0;
          w_cs_nxt    = 1'b1;
          w_we_nxt    = 1'b1;
          w_a_nxt     = '0;
          w_d_nxt     = '0;
        end else if (i_evt_valid && w_ready) begin
          w_state_nxt = S_RD;
          w_cap       = 1'b1;
          w_cs_nxt    = 1'b1;
          w_a_nxt     = i_evt_addr;
        end
      end
      S_RD: begin
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_state_nxt = S_IDLE;
        w_cs_nxt    = 1'b1;
        w_we_nxt    = 1'b1;
        w_a_nxt     = r_addr;
        w_d_nxt     = w_word;
        if (w_fire) begin
          w_spk_valid_nxt = 1'b1;
          w_spk_addr_nxt  = r_addr;
        end
      end
      S_CLR: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt    = S_IDLE;
          w_clr_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_cs_nxt  = 1'b1;
          w_we_nxt  = 1'b1;
          w_a_nxt   = w_cnt_inc[ADDR_WIDTH-1:0];
          w_d_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_rdy_arm   <= 1'b0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_a         <= '0;
      r_d         <= '0;
      r_spk_valid <= 1'b0;
      r_spk_addr  <= '0;
      r_clr_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_rdy_arm   <= 1'b1;
      r_cs        <= w_cs_nxt;
      r_we        <= w_we_nxt;
      r_a         <= w_a_nxt;
      r_d         <= w_d_nxt;
      r_spk_valid <= w_spk_valid_nxt;
      r_spk_addr  <= w_spk_addr_nxt;
      r_clr_done  <= w_clr_done_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Event fields captured at the handshake
  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_weight <= '0;
      r_thr    <= '0;
    end else if (w_cap) begin
      r_addr   <= i_evt_addr;
      r_weight <= i_evt_weight;
      r_thr    <= i_thr;
    end
  end

  assign o_busy      = r_busy;
  assign o_clr_done  = r_clr_done;
  assign o_spk_valid = r_spk_valid;
  assign o_spk_addr  = r_spk_addr;
  assign o_sram_cs   = r_cs;
  assign o_sram_we   = r_we;
  assign o_sram_a    = r_a;
  assign o_sram_d    = r_d;

endmodule

// File: tb/tb_post_neuron_update_ctrl.sv
// Directed bench for post_neuron_update_ctrl with a behavioural 256x32 SRAM (default build, no leak).
module tb_post_neuron_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        evt_valid, evt_ready;
  logic [7:0]  evt_addr, evt_weight;
  logic [15:0] thr;
  logic        clr_start, busy, clr_done, spk_valid;
  logic [7:0]  spk_addr, sram_a;
  logic        sram_cs, sram_we;
  logic [31:0] sram_d, sram_q;

  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  post_neuron_update_ctrl dut (
    .i_ck        (clk),
    .i_rst_n     (rst_n),
    .i_evt_valid (evt_valid),
    .o_evt_ready (evt_ready),
    .i_evt_addr  (evt_addr),
    .i_evt_weight(evt_weight),
    .i_thr       (thr),
    .i_clr_start (clr_start),
    .o_busy      (busy),
    .o_clr_done  (clr_done),
    .o_spk_valid (spk_valid),
    .o_spk_addr  (spk_addr),
    .o_sram_cs   (sram_cs),
    .o_sram_we   (sram_we),
    .o_sram_a    (sram_a),
    .o_sram_d    (sram_d),
    .i_sram_q    (sram_q)
  );

  // Synchronous SRAM: Q valid the cycle after a read; bench preload port for setup
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (sram_cs) begin
      if (sram_we) mem[sram_a] <= sram_d;
      else         sram_q      <= mem[sram_a];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // One full event: handshake, read, then check the write-back and spike at t+3
  task automatic do_evt(input logic [7:0] a, input logic [7:0] w, input logic [15:0] t,
                        input logic [31:0] exp_word, input logic exp_spk, input logic [7:0] exp_spk_a);
    evt_valid = 1'b1; evt_addr = a; evt_weight = w; thr = t;
    chk("evt_ready", 32'(evt_ready), 32'd1);
    tick();
    evt_valid = 1'b0;
    chk("rd_cs_we", 32'({sram_cs, sram_we, busy}), 32'b101);
    chk("rd_addr", 32'(sram_a), 32'(a));
    tick();
    tick();
    chk("wr_cs_we", 32'({sram_cs, sram_we}), 32'b11);
    chk("wr_addr", 32'(sram_a), 32'(a));
    chk("wr_word", sram_d, exp_word);
    chk("spk_valid", 32'(spk_valid), 32'(exp_spk));
    chk("spk_addr", 32'(spk_addr), 32'(exp_spk_a));
  endtask

  initial begin
    int clr_bad;
    rst_n = 1'b0; evt_valid = 1'b0; evt_addr = '0; evt_weight = '0; thr = '0;
    clr_start = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    #3;
    chk("rst_ctrl", 32'({evt_ready, busy, clr_done, spk_valid, sram_cs, sram_we}), 32'd0);
    chk("rst_bus", {8'h0, spk_addr, sram_a, 8'h0} | sram_d, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rdy_after_rel", 32'(evt_ready), 32'd0);
    tick();
    chk("rdy_next", 32'({evt_ready, busy}), 32'b10);

    // Basic fire, then back-to-back to the same neuron
    preload(8'd7, 32'h0003_0050);
    do_evt(8'd7, 8'h20, 16'h0064, 32'h0004_0000, 1'b1, 8'd7);
    do_evt(8'd7, 8'h10, 16'h0064, 32'h0004_0010, 1'b0, 8'd7);
    chk("spk_pulse", 32'(spk_valid), 32'd0);

    // Positive and negative saturation
    preload(8'd9, 32'h0000_7FF0);
    do_evt(8'd9, 8'h7F, 16'h7FFF, 32'h0001_0000, 1'b1, 8'd9);
    preload(8'd10, 32'h0000_8005);
    do_evt(8'd10, 8'h80, 16'h7FFF, 32'h0000_8000, 1'b0, 8'd9);

    // Negative weight, spike count saturation, signed threshold boundary
    preload(8'd11, 32'h0002_0010);
    do_evt(8'd11, 8'hFD, 16'h0064, 32'h0002_000D, 1'b0, 8'd9);
    preload(8'd12, 32'hFFFF_0060);
    do_evt(8'd12, 8'h10, 16'h0064, 32'hFFFF_0000, 1'b1, 8'd12);
    preload(8'd13, 32'h0000_FFF0);
    do_evt(8'd13, 8'h01, 16'hFFF1, 32'h0001_0000, 1'b1, 8'd13);
    preload(8'd14, 32'h0000_FFF0);
    do_evt(8'd14, 8'h01, 16'hFFF2, 32'h0000_FFF1, 1'b0, 8'd13);

    // Reset during WR abandons the write
    preload(8'd20, 32'h0000_0010);
    evt_valid = 1'b1; evt_addr = 8'd20; evt_weight = 8'h70; thr = 16'h0064;
    tick();
    evt_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midwr_ctrl", 32'({evt_ready, busy, clr_done, spk_valid, sram_cs, sram_we}), 32'd0);
    chk("midwr_bus", {8'h0, spk_addr, sram_a, 8'h0} | sram_d, 32'd0);
    @(posedge clk); #1;
    chk("midwr_hold", 32'({busy, spk_valid, sram_cs, sram_we}), 32'd0);
    rst_n = 1'b1;
    chk("midwr_rdy0", 32'(evt_ready), 32'd0);
    tick();
    chk("midwr_rdy1", 32'(evt_ready), 32'd1);
    chk("midwr_mem", mem[20], 32'h0000_0010);

    // Clear has priority over a simultaneous event
    clr_start = 1'b1;
    evt_valid = 1'b1; evt_addr = 8'd7; evt_weight = 8'h20; thr = 16'h0064;
    #1;
    chk("clr_rdy_block", 32'(evt_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    clr_bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (!(sram_cs && sram_we && busy && !evt_ready && !clr_done &&
            sram_a == 8'(i) && sram_d == 32'd0)) clr_bad++;
      tick();
    end
    chk("clr_sweep_bad", 32'(clr_bad), 32'd0);
    chk("clr_done", 32'({clr_done, busy, sram_cs, evt_ready}), 32'b1001);
    chk("clr_mem0", mem[0], 32'd0);
    chk("clr_mem255", mem[255], 32'd0);
    chk("clr_mem12", mem[12], 32'd0);
    tick();
    evt_valid = 1'b0;
    chk("clr_done_pulse", 32'(clr_done), 32'd0);
    chk("post_clr_rd", 32'({sram_cs, sram_we, busy}), 32'b101);
    chk("post_clr_a", 32'(sram_a), 32'd7);
    tick();
    tick();
    chk("post_clr_word", sram_d, 32'h0000_0020);
    chk("post_clr_spk", 32'({spk_valid, spk_addr}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
